// File: rtl/safecrack_pkg.sv
// Shared types and constants for the safecrack button front end.
// Holds the button width, the capture-state enum and the debounce default.
package safecrack_pkg;

    localparam int BTN_W            = 4;
    localparam int DEBOUNCE_DEFAULT = 500000;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_HELD,
        CAP_EMIT
    } cap_state_t;

    // Level a button reads when not pressed, in btn_raw polarity.
    function automatic logic [BTN_W-1:0] released_level(input int active_low);
        return (active_low != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit synchronizer plus debounce counter.
// Ports: clk, rst (sync, active high), din (async raw), dout (debounced level).
module btn_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RST_LEVEL       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= RST_LEVEL;
            sync1 <= RST_LEVEL;
            dout  <= RST_LEVEL;
            cnt   <= '0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
            if (sync1 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Level held long enough: accept it and restart.
                dout <= sync1;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_press_cond.sv
// Button conditioner: debounces four buttons and emits one press event
// per chord. Ports: clk, rst, btn_raw, press_ready -> press_valid,
// press_code, btn_stable, overrun (sticky drop flag).
module btn_press_cond
    import safecrack_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_W-1:0] btn_raw,
    input  logic             press_ready,
    output logic             press_valid,
    output logic [BTN_W-1:0] press_code,
    output logic [BTN_W-1:0] btn_stable,
    output logic             overrun
);

    localparam logic [BTN_W-1:0] REL = released_level(ACTIVE_LOW);

    cap_state_t       state;
    cap_state_t       state_n;
    logic [BTN_W-1:0] acc;
    logic [BTN_W-1:0] acc_n;
    logic [BTN_W-1:0] pressed;
    logic             load;
    logic             drop;

    for (genvar i = 0; i < BTN_W; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_LEVEL       (REL[i])
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .din  (btn_raw[i]),
            .dout (btn_stable[i])
        );
    end

    // Pressed mask is active-high regardless of button polarity.
    assign pressed = btn_stable ^ REL;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CAP_IDLE;
            acc   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state)
            CAP_IDLE: begin
                if (|pressed) begin
                    state_n = CAP_HELD;
                    acc_n   = pressed;
                end
            end
            CAP_HELD: begin
                acc_n = acc | pressed;
                if (pressed == '0) begin
                    state_n = CAP_EMIT;
                end
            end
            CAP_EMIT: begin
                state_n = CAP_IDLE;
                // Output slot free or being drained this cycle.
                if (!press_valid || press_ready) begin
                    load = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_n = CAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_valid <= 1'b0;
            press_code  <= REL;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                press_valid <= 1'b1;
                press_code  <= acc ^ REL;
            end else if (press_valid && press_ready) begin
                press_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_press_cond.sv
// Directed bench for btn_press_cond with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Expected event codes go through a scoreboard queue.
module tb_btn_press_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       press_ready;
    logic       press_valid;
    logic [3:0] press_code;
    logic [3:0] btn_stable;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];

    btn_press_cond #(
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .press_ready (press_ready),
        .press_valid (press_valid),
        .press_code  (press_code),
        .btn_stable  (btn_stable),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for press_valid, then compare against the scoreboard.
    task automatic wait_event(input string tag);
        logic [3:0] exp;
        for (int i = 0; i < 40; i++) begin
            if (press_valid) break;
            cyc(1);
        end
        chk({tag, "_valid"}, {3'b0, press_valid}, 4'b0001);
        exp = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
        chk({tag, "_code"}, press_code, exp);
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        btn_raw = code;
        cyc(hold);
        btn_raw = 4'b1111;
    endtask

    initial begin
        logic ok;
        rst         = 1'b1;
        btn_raw     = 4'b1111;
        press_ready = 1'b1;
        cyc(3);
        chk("rst_stable", btn_stable, 4'b1111);
        chk("rst_valid", {3'b0, press_valid}, 4'b0000);
        chk("rst_code", press_code, 4'b1111);
        chk("rst_overrun", {3'b0, overrun}, 4'b0000);
        rst = 1'b0;
        cyc(2);

        // Clean press: exact debounce and release-to-valid latency.
        btn_raw = 4'b1110;
        sb.push_back(4'b1110);
        cyc(5);
        chk("clean_stable_e5", btn_stable, 4'b1111);
        cyc(1);
        chk("clean_stable_e6", btn_stable, 4'b1110);
        cyc(14);
        btn_raw = 4'b1111;
        cyc(5);
        chk("clean_rel_e5", btn_stable, 4'b1110);
        cyc(1);
        chk("clean_rel_e6", btn_stable, 4'b1111);
        chk("clean_nv_e6", {3'b0, press_valid}, 4'b0000);
        cyc(1);
        chk("clean_nv_e7", {3'b0, press_valid}, 4'b0000);
        cyc(1);
        chk("clean_valid", {3'b0, press_valid}, 4'b0001);
        chk("clean_code", press_code, sb.pop_front());
        cyc(1);
        chk("clean_drain", {3'b0, press_valid}, 4'b0000);

        // Bounce on bit 1 never reaches the debounce threshold.
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) btn_raw[1] = ~btn_raw[1];
            cyc(1);
            if (btn_stable !== 4'b1111 || press_valid !== 1'b0) ok = 1'b0;
        end
        btn_raw = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (btn_stable !== 4'b1111 || press_valid !== 1'b0) ok = 1'b0;
        end
        chk("bounce_quiet", {3'b0, ok}, 4'b0001);

        // Chord: bit 0, then bit 2 three cycles later.
        btn_raw = 4'b1110;
        cyc(3);
        sb.push_back(4'b1010);
        press(4'b1010, 10);
        wait_event("chord");
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (press_valid !== 1'b0) ok = 1'b0;
        end
        chk("chord_single", {3'b0, ok}, 4'b0001);

        // Backpressure: second event dropped, overrun set.
        press_ready = 1'b0;
        sb.push_back(4'b1110);
        press(4'b1110, 10);
        wait_event("bp1");
        chk("bp1_overrun", {3'b0, overrun}, 4'b0000);
        press(4'b0111, 10);
        cyc(12);
        chk("bp2_valid", {3'b0, press_valid}, 4'b0001);
        chk("bp2_code", press_code, 4'b1110);
        chk("bp2_overrun", {3'b0, overrun}, 4'b0001);
        press_ready = 1'b1;
        cyc(1);
        chk("bp_drain", {3'b0, press_valid}, 4'b0000);

        // Accept and load in the same EMIT cycle.
        press_ready = 1'b0;
        sb.push_back(4'b1110);
        press(4'b1110, 10);
        wait_event("sim_old");
        sb.push_back(4'b1101);
        press(4'b1101, 10);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (btn_stable === 4'b1111) break;
        end
        chk("sim_released", btn_stable, 4'b1111);
        cyc(1);
        press_ready = 1'b1;
        cyc(1);
        press_ready = 1'b0;
        chk("sim_valid", {3'b0, press_valid}, 4'b0001);
        chk("sim_code", press_code, sb.pop_front());

        // Reset while held: event discarded.
        press_ready = 1'b1;
        cyc(1);
        chk("pre_rst_drain", {3'b0, press_valid}, 4'b0000);
        btn_raw = 4'b0111;
        cyc(8);
        chk("held_stable", btn_stable, 4'b0111);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_stable", btn_stable, 4'b1111);
        chk("mid_rst_code", press_code, 4'b1111);
        chk("mid_rst_overrun", {3'b0, overrun}, 4'b0000);
        cyc(9);
        btn_raw = 4'b1111;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (press_valid !== 1'b0) ok = 1'b0;
        end
        chk("rst_no_event", {3'b0, ok}, 4'b0001);
        chk("rst_overrun_end", {3'b0, overrun}, 4'b0000);
        chk("sb_empty", sb.size() == 0 ? 4'b0001 : 4'b0000, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_press_cond.md
BTN_PRESS_COND -- requirements
Module: btn_press_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive cycles a synchronized level must hold before it is accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, meaning a pressed button reads 0 on btn_raw.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port btn_raw, input, 4, asynchronous raw push-button levels.
REQ-006 SHALL have port press_ready, input, 1, asserted by the downstream lock FSM when it can take a press event.
REQ-007 SHALL have port press_valid, output, 1, a completed press event is held in the output register.
REQ-008 SHALL have port press_code, output, 4, the button pattern of the event in btn_raw polarity, directly comparable to stored passcodes.
REQ-009 SHALL have port btn_stable, output, 4, debounced button levels in btn_raw polarity.
REQ-010 SHALL have port overrun, output, 1, sticky flag: at least one event was dropped.

Function
REQ-011 SHALL pass each btn_raw bit through a two-flop synchronizer before any other use.
REQ-012 SHALL debounce each bit independently: a per-bit counter increments while the synchronized bit differs from btn_stable and clears whenever they match.
REQ-013 SHALL update the btn_stable bit and clear its counter in the cycle the counter reaches DEBOUNCE_CYCLES-1; raw-to-stable latency is therefore exactly 2+DEBOUNCE_CYCLES cycles for a clean edge.
REQ-014 SHALL size counters to $clog2(DEBOUNCE_CYCLES)+1 bits, never wrapping; DEBOUNCE_CYCLES=1 shall accept a changed level after one cycle.
REQ-015 SHALL run a capture FSM with states IDLE, HELD, EMIT.
REQ-016 IDLE -> HELD when any btn_stable bit becomes pressed; the accumulator is loaded with the pressed mask.
REQ-017 In HELD the accumulator SHALL OR in every newly pressed bit (chorded presses merge into one event).
REQ-018 HELD -> EMIT when all btn_stable bits are released; EMIT -> IDLE unconditionally after one cycle.
REQ-019 In EMIT, if press_valid is 0 or press_ready is 1 in that cycle, the output register SHALL load the accumulator converted to btn_raw polarity and press_valid SHALL be 1 in the following cycle.
REQ-020 In EMIT, if press_valid is 1 and press_ready is 0, the new event SHALL be dropped and overrun set; the held event is unchanged.
REQ-021 press_valid SHALL fall in the cycle after press_valid and press_ready are both 1, unless a new event loads in that same cycle (REQ-019), in which case it stays 1 with the new code.
REQ-022 press_code SHALL be stable while press_valid is 1 and press_ready is 0.
REQ-023 Release-to-valid latency: press_valid rises exactly 2 cycles after the cycle btn_stable returns to all-released.

Reset
REQ-024 On rst: synchronizer flops and btn_stable SHALL load the released level (4'b1111 when ACTIVE_LOW=1, else 4'b0000).
REQ-025 On rst: counters, accumulator cleared, FSM to IDLE, press_valid 0, press_code 4'b1111 (ACTIVE_LOW=1) else 4'b0000, overrun 0.
REQ-026 Reset mid-press SHALL discard the event; a button still held after reset SHALL produce an event only once it is debounced as pressed and then released.

Structure
REQ-027 The shared package safecrack_pkg SHALL hold BTN_W=4, the capture-state enum, and the DEBOUNCE_CYCLES default.
REQ-028 Synchronizer plus debounce counter for one bit SHALL be sub-module btn_debounce, instantiated BTN_W times.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-029 Clean press: btn_raw 1111->1110 for 20 cycles, then back to 1111 -> btn_stable[0]=0 six cycles after the edge; press_valid=1 with press_code=1110 two cycles after btn_stable returns to 1111.
REQ-030 Bounce: btn_raw[1] toggles every 2 cycles for 30 cycles, then holds 1 -> btn_stable stays 1111, no press_valid.
REQ-031 Chord: press bit 0, 3 cycles later also bit 2, release both -> exactly one event, press_code=1010.
REQ-032 Backpressure: press_ready=0, two complete presses (1110, then 0111) -> press_code stays 1110, overrun=1 after the second release; raise press_ready -> press_valid drops next cycle.
REQ-033 Simultaneous accept and load: press_valid=1, press_ready=1 in the EMIT cycle of a new 1101 press -> press_valid stays 1, press_code=1101.
REQ-034 Reset mid-press: rst asserted while in HELD with bit 3 held, bit 3 released 10 cycles later -> no event; overrun=0.
